// File: rtl/pwm_dac_slew_sched_if.sv
// Bus bundle for the PWM DAC slew scheduler: register-file side inputs and
// encoded PWM configuration outputs.
interface pwm_dac_slew_sched_if #(
  parameter int DIV_W = 16
);
  logic             en_i;
  logic [DIV_W-1:0] div_i;
  logic [11:0]      step_i;
  logic             tgt_wr_i;
  logic [1:0]       tgt_ch_i;
  logic [11:0]      tgt_val_i;
  logic [23:0]      dac_a_o;
  logic [23:0]      dac_b_o;
  logic [23:0]      dac_c_o;
  logic [23:0]      dac_d_o;
  logic [3:0]       done_o;
  logic             busy_o;

  modport master (
    output en_i, div_i, step_i, tgt_wr_i, tgt_ch_i, tgt_val_i,
    input  dac_a_o, dac_b_o, dac_c_o, dac_d_o, done_o, busy_o
  );

  modport slave (
    input  en_i, div_i, step_i, tgt_wr_i, tgt_ch_i, tgt_val_i,
    output dac_a_o, dac_b_o, dac_c_o, dac_d_o, done_o, busy_o
  );
endinterface

// File: rtl/pwm_dac_slew_sched.sv
// Slew-rate-limited scheduler: on each accepted tick, sweeps channels a..d once,
// moving each current value toward its target by at most step, then PWM-encodes it.
module pwm_dac_slew_sched #(
  parameter int DIV_W = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pwm_dac_slew_sched_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, UPD3} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             upd_en;
  logic [1:0]       upd_ch;
  logic             busy;
  logic [11:0]      tgt [4];
  logic [11:0]      cur [4];
  logic [23:0]      dac_p1 [4];
  logic [3:0]       done_p1;

  function automatic logic [11:0] slew(input logic [11:0] c, input logic [11:0] t,
                                       input logic [11:0] s);
    logic signed [12:0] d;
    logic [12:0]        mag;
    d   = $signed({1'b0, t}) - $signed({1'b0, c});
    mag = d[12] ? $unsigned(-d) : $unsigned(d);
    if (s == 12'd0 || mag <= {1'b0, s})
      return t;
    else if (d[12])
      return c - s;
    else
      return c + s;
  endfunction

  // Low 16 bits spread the 4 LSBs over the PWM frame (b3 every 2nd slot, b2 every 4th, ...)
  function automatic logic [23:0] encode(input logic [11:0] v);
    return {v[11:4], 1'b0, v[3], v[2], v[3], v[1], v[3], v[2], v[3], v[0],
            v[3], v[2], v[3], v[1], v[3], v[2], v[3]};
  endfunction

  assign tick = bus.en_i && (cnt == bus.div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (!bus.en_i || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    upd_en    = 1'b0;
    upd_ch    = 2'd0;
    case (state)
      IDLE: if (tick) state_nxt = UPD0;
      UPD0: begin state_nxt = UPD1; upd_en = 1'b1; upd_ch = 2'd0; end
      UPD1: begin state_nxt = UPD2; upd_en = 1'b1; upd_ch = 2'd1; end
      UPD2: begin state_nxt = UPD3; upd_en = 1'b1; upd_ch = 2'd2; end
      UPD3: begin state_nxt = IDLE; upd_en = 1'b1; upd_ch = 2'd3; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Stage p0: target/current state; stage p1: registered encode and done flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        tgt[k]    <= '0;
        cur[k]    <= '0;
        dac_p1[k] <= '0;
      end
      done_p1 <= 4'hF;
    end else begin
      if (upd_en)
        cur[upd_ch] <= slew(cur[upd_ch], tgt[upd_ch], bus.step_i);
      if (bus.tgt_wr_i)
        tgt[bus.tgt_ch_i] <= bus.tgt_val_i;
      for (int k = 0; k < 4; k++) begin
        dac_p1[k]  <= encode(cur[k]);
        done_p1[k] <= (cur[k] == tgt[k]);
      end
    end
  end

  assign bus.dac_a_o = dac_p1[0];
  assign bus.dac_b_o = dac_p1[1];
  assign bus.dac_c_o = dac_p1[2];
  assign bus.dac_d_o = dac_p1[3];
  assign bus.done_o  = done_p1;
  assign bus.busy_o  = busy;

endmodule

// File: tb/tb_pwm_dac_slew_sched.sv
// Bench for pwm_dac_slew_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pwm_dac_slew_sched;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  always #5 clk_i = ~clk_i;

  pwm_dac_slew_sched_if #(.DIV_W(16)) bus ();
  pwm_dac_slew_sched #(.DIV_W(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  // ---------------- behavioural model ----------------
  int          m_tgt [4];
  int          m_cur [4];
  int          m_n;
  int          m_ph;
  logic [23:0] m_dac [4];
  logic [3:0]  m_done;
  logic        m_busy;

  function automatic int m_slew(int c, int t, int s);
    int d;
    d = t - c;
    if (s == 0 || (d < 0 ? -d : d) <= s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  // Slot j (1..15, counted from the field MSB) carries bit 3-ctz(j) of the nibble
  function automatic logic [23:0] m_enc(int v);
    logic [23:0] w;
    int tz, jj;
    w = '0;
    w[23:16] = v[11:4];
    for (int j = 1; j < 16; j++) begin
      tz = 0; jj = j;
      while (jj % 2 == 0) begin tz++; jj = jj / 2; end
      w[15-j] = v[3-tz];
    end
    return w;
  endfunction

  function automatic bit m_tick();
    int dv;
    dv = int'(bus.div_i);
    return bus.en_i && ((m_n % (dv + 1)) == dv);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        m_tgt[k] <= 0; m_cur[k] <= 0; m_dac[k] <= '0;
      end
      m_done <= 4'hF; m_busy <= 1'b0; m_ph <= -1; m_n <= 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_dac[k]  <= m_enc(m_cur[k]);
        m_done[k] <= (m_cur[k] == m_tgt[k]);
      end
      if (m_ph >= 0)
        m_cur[m_ph[1:0]] <= m_slew(m_cur[m_ph[1:0]], m_tgt[m_ph[1:0]], int'(bus.step_i));
      if (bus.tgt_wr_i)
        m_tgt[bus.tgt_ch_i] <= int'(bus.tgt_val_i);
      if (m_ph >= 0 && m_ph < 3) begin m_ph <= m_ph + 1; m_busy <= 1'b1; end
      else if (m_ph == 3)        begin m_ph <= -1;       m_busy <= 1'b0; end
      else if (m_tick())         begin m_ph <= 0;        m_busy <= 1'b1; end
      m_n <= bus.en_i ? m_n + 1 : 0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_on && !rst_i) begin
      checks++;
      if (bus.dac_a_o !== m_dac[0] || bus.dac_b_o !== m_dac[1] ||
          bus.dac_c_o !== m_dac[2] || bus.dac_d_o !== m_dac[3]) begin
        errors++;
        $display("FAIL model_dac t=%0t got %h %h %h %h expected %h %h %h %h", $time,
                 bus.dac_a_o, bus.dac_b_o, bus.dac_c_o, bus.dac_d_o,
                 m_dac[0], m_dac[1], m_dac[2], m_dac[3]);
      end
      checks++;
      if (bus.done_o !== m_done) begin
        errors++;
        $display("FAIL model_done t=%0t got %b expected %b", $time, bus.done_o, m_done);
      end
      checks++;
      if (bus.busy_o !== m_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b expected %b", $time, bus.busy_o, m_busy);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [11:0] v);
    bus.tgt_wr_i = 1'b1; bus.tgt_ch_i = ch; bus.tgt_val_i = v;
    cyc(1);
    bus.tgt_wr_i = 1'b0;
  endtask

  task automatic wait_rise(input string nm);
    int n;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin cyc(1); n++; end
    while (bus.busy_o !== 1'b1 && n < 200) begin cyc(1); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout t=%0t got no sweep expected busy rise", nm, $time);
    end
  endtask

  task automatic run_sweep(input string nm);
    bus.en_i = 1'b1;
    wait_rise(nm);
    bus.en_i = 1'b0;
    cyc(5);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int hi;
    bus.en_i = 1'b0; bus.div_i = '0; bus.step_i = '0;
    bus.tgt_wr_i = 1'b0; bus.tgt_ch_i = '0; bus.tgt_val_i = '0;

    chk("pin_enc_a5b", 32'(m_enc(32'hA5B)), 32'hA55DDD);
    chk("pin_enc_0f8", 32'(m_enc(32'h0F8)), 32'h0F5555);
    chk("pin_slew_clamp", 32'(m_slew(32'h0F0, 32'h0F8, 16)), 32'h0F8);
    chk("pin_slew_down", 32'(m_slew(32'h010, 0, 32)), 32'h0);

    cyc(3);
    chk("rst_dac_a", 32'(bus.dac_a_o), 32'h0);
    chk("rst_done", 32'(bus.done_o), 32'hF);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    rst_i = 1'b0;
    chk_on = 1'b1;
    cyc(1);

    // Jump mode
    bus.step_i = 12'd0; bus.div_i = 16'd3;
    wr(2'd1, 12'hA5B);
    wr(2'd0, 12'h100);
    cyc(1);
    chk("jump_done_before", 32'(bus.done_o), 32'hC);
    bus.en_i = 1'b1;
    wait_rise("jump");
    cyc(2);
    chk("jump_dac_a", 32'(bus.dac_a_o), 32'h100000);
    chk("jump_dac_b_early", 32'(bus.dac_b_o), 32'h0);
    cyc(1);
    chk("jump_dac_b", 32'(bus.dac_b_o), 32'hA55DDD);
    chk("jump_done_b", 32'(bus.done_o[1]), 32'h1);

    // Asynchronous reset in UPD2
    wait_rise("rst_sweep");
    cyc(2);
    chk("pre_rst_dac_a", 32'(bus.dac_a_o), 32'h100000);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_dacs", 32'(bus.dac_a_o | bus.dac_b_o | bus.dac_c_o | bus.dac_d_o), 32'h0);
    chk("mid_rst_done", 32'(bus.done_o), 32'hF);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'h0);
    cyc(1);
    rst_i = 1'b0;
    n = 0;
    while (bus.busy_o !== 1'b1 && n < 50) begin cyc(1); n++; end
    chk("first_tick_latency", 32'(n), 32'd4);
    bus.en_i = 1'b0;
    cyc(6);

    // Slew ramp
    bus.step_i = 12'd16; bus.div_i = 16'd9;
    wr(2'd0, 12'h100);
    bus.en_i = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      wait_rise("ramp");
      cyc(2);
      chk("ramp_dac_a_hi", 32'(bus.dac_a_o[23:16]), 32'(s));
      chk("ramp_done_a", 32'(bus.done_o[0]), 32'(s == 16));
    end
    bus.en_i = 1'b0;
    cyc(6);

    // Clamp at target, upward and downward
    bus.div_i = 16'd2; bus.step_i = 12'd0;
    wr(2'd0, 12'h0F0);
    wr(2'd3, 12'h010);
    run_sweep("clamp_setup");
    bus.step_i = 12'd16;
    wr(2'd0, 12'h0F8);
    run_sweep("clamp_up");
    chk("clamp_up_dac_a", 32'(bus.dac_a_o), 32'h0F5555);
    chk("clamp_up_done_a", 32'(bus.done_o[0]), 32'h1);
    bus.step_i = 12'h020;
    wr(2'd3, 12'h000);
    run_sweep("clamp_down");
    chk("clamp_down_dac_d", 32'(bus.dac_d_o), 32'h0);
    chk("clamp_down_done_d", 32'(bus.done_o[3]), 32'h1);

    // Write to ch2 collides with UPD2
    bus.step_i = 12'h100;
    bus.en_i = 1'b1;
    wait_rise("collide");
    bus.en_i = 1'b0;
    cyc(2);
    wr(2'd2, 12'h800);
    cyc(3);
    chk("collide_dac_c", 32'(bus.dac_c_o), 32'h0);
    chk("collide_done_c", 32'(bus.done_o[2]), 32'h0);
    run_sweep("collide_next");
    chk("collide_next_dac_c", 32'(bus.dac_c_o), 32'h100000);

    // Dropped ticks with div=0, then en falling in UPD1
    bus.div_i = 16'd0;
    bus.en_i = 1'b1;
    wait_rise("drop");
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy_o === 1'b1) hi++;
      cyc(1);
    end
    chk("drop_busy_duty", 32'(hi), 32'd16);
    wait_rise("drop_stop");
    cyc(1);
    bus.en_i = 1'b0;
    cyc(2);
    chk("en_fall_busy_upd3", 32'(bus.busy_o), 32'h1);
    cyc(1);
    chk("en_fall_busy_idle", 32'(bus.busy_o), 32'h0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy_o === 1'b1) hi++;
      cyc(1);
    end
    chk("en_fall_no_sweep", 32'(hi), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #3 rst_i = 1'b1;
        #1 rst_i = 1'b0;
      end
      cyc(1);
      bus.en_i = ($urandom_range(7) != 0);
      if (!bus.en_i) bus.div_i = 16'($urandom_range(5));
      case ($urandom_range(3))
        0: bus.step_i = 12'd0;
        1: bus.step_i = 12'($urandom_range(64));
        2: bus.step_i = 12'($urandom_range(4095));
        default: ;
      endcase
      bus.tgt_wr_i  = ($urandom_range(2) == 0);
      bus.tgt_ch_i  = 2'($urandom_range(3));
      case ($urandom_range(5))
        0: bus.tgt_val_i = 12'h000;
        1: bus.tgt_val_i = 12'hFFF;
        default: bus.tgt_val_i = 12'($urandom_range(4095));
      endcase
    end
    bus.tgt_wr_i = 1'b0;
    bus.en_i = 1'b0;
    cyc(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
